// File: rtl/mult_share_arb_pkg.sv
// mult_share_arb_pkg: shared widths, tag record and id-width helper
package mult_share_arb_pkg;
    localparam int A_W_DEF    = 12;
    localparam int B_W_DEF    = 14;
    localparam int P_W_DEF    = 16;
    localparam int TAG_ID_MAX = 3;

    // One tag travels alongside each operation through the multiplier pipeline
    typedef struct packed {
        logic                  valid;
        logic [TAG_ID_MAX-1:0] id;
    } tag_t;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mult_share_arb_rr_arbiter.sv
// mult_share_arb_rr_arbiter: combinational round-robin grant starting after the pointer
module mult_share_arb_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);
    int w_j;

    // Scan farthest-first so the nearest valid slot after the pointer wins last
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_j = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[w_j]) begin
                o_gnt      = '0;
                o_gnt[w_j] = 1'b1;
                o_idx      = ID_W'(w_j);
                o_any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin sharing of one pipelined multiplier with tagged result return
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int A_W          = A_W_DEF,
    parameter int B_W          = B_W_DEF,
    parameter int P_W          = P_W_DEF,
    parameter int MULT_LATENCY = 1,
    parameter int ID_W         = id_width(NUM_REQ)
) (
    input  logic                   clock,
    input  logic                   aclr,
    input  logic                   hold,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic [A_W-1:0]         mult_dataa,
    output logic [B_W-1:0]         mult_datab,
    input  logic [P_W-1:0]         mult_result,
    output logic [NUM_REQ-1:0]     res_valid,
    output logic [P_W-1:0]         res_data,
    output logic [ID_W-1:0]        res_id,
    output logic [ID_W:0]          inflight
);
    logic [NUM_REQ-1:0] w_req;
    logic [ID_W-1:0]    w_idx;
    logic               w_hs;
    logic               w_rv;
    logic [A_W-1:0]     r_dataa;
    logic [B_W-1:0]     r_datab;
    logic [ID_W-1:0]    r_ptr;
    tag_t               r_tag [MULT_LATENCY];
    logic [NUM_REQ-1:0] r_res_valid;
    logic [ID_W-1:0]    r_res_id;
    logic [ID_W:0]      r_inflight;

    assign w_req = req_valid & {NUM_REQ{~hold}};
    assign w_rv  = |r_res_valid;

    mult_share_arb_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (req_ready),
        .o_idx (w_idx),
        .o_any (w_hs)
    );

    // Capture the granted operand pair and advance the rotation pointer
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            r_dataa <= '0;
            r_datab <= '0;
            r_ptr   <= ID_W'(NUM_REQ - 1);
        end else if (w_hs) begin
            r_dataa <= req_a[int'(w_idx)*A_W +: A_W];
            r_datab <= req_b[int'(w_idx)*B_W +: B_W];
            r_ptr   <= w_idx;
        end
    end

    // Tags shadow the multiplier stages; the last one decodes into the result strobe
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            for (int s = 0; s < MULT_LATENCY; s++) r_tag[s] <= '0;
            r_res_valid <= '0;
            r_res_id    <= '0;
        end else begin
            r_tag[0] <= '{valid: w_hs, id: TAG_ID_MAX'(w_idx)};
            for (int s = 1; s < MULT_LATENCY; s++) r_tag[s] <= r_tag[s-1];
            r_res_valid <= r_tag[MULT_LATENCY-1].valid ? NUM_REQ'(1) << r_tag[MULT_LATENCY-1].id : '0;
            if (r_tag[MULT_LATENCY-1].valid) r_res_id <= r_tag[MULT_LATENCY-1].id[ID_W-1:0];
        end
    end

    // Count operations accepted but not yet presented on the result port
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) r_inflight <= '0;
        else r_inflight <= (w_hs && !w_rv) ? r_inflight + (ID_W+1)'(1) :
                           (!w_hs && w_rv) ? r_inflight - (ID_W+1)'(1) : r_inflight;
    end

    assign mult_dataa = r_dataa;
    assign mult_datab = r_datab;
    assign res_valid  = r_res_valid;
    assign res_id     = r_res_id;
    assign res_data   = mult_result;
    assign inflight   = r_inflight;
endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: randomized and directed checks against a queue-based reference model
module tb_mult_share_arb;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int BW = 14;
    localparam int PW = 16;
    localparam int IW = 2;

    logic            clock = 1'b0;
    logic            aclr = 1'b1;
    logic            hold = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a = '0;
    logic [N*BW-1:0] req_b = '0;
    logic [AW-1:0]   mult_dataa;
    logic [BW-1:0]   mult_datab;
    logic [PW-1:0]   mult_result = '0;
    logic [N-1:0]    res_valid;
    logic [PW-1:0]   res_data;
    logic [IW-1:0]   res_id;
    logic [IW:0]     inflight;

    typedef struct {
        int            due;
        int            id;
        logic [PW-1:0] p;
    } op_t;

    op_t             q[$];
    int              n_tests = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              m_last = N - 1;
    int              n_ops = 0;
    logic [N*AW-1:0] ra;
    logic [N*BW-1:0] rb;

    mult_share_arb dut (
        .clock       (clock),
        .aclr        (aclr),
        .hold        (hold),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mult_dataa  (mult_dataa),
        .mult_datab  (mult_datab),
        .mult_result (mult_result),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_id      (res_id),
        .inflight    (inflight)
    );

    always #5 clock = ~clock;

    function automatic logic [PW-1:0] prod_top(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b);
        longint p;
        logic [63:0] u;
        p = longint'(a) * longint'(b);
        u = p;
        return u[25:10];
    endfunction

    // Shared multiplier with one register stage
    always_ff @(posedge clock) mult_result <= prod_top(mult_dataa, mult_datab);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cyc_step(input logic h, input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N*BW-1:0] b);
        logic [N-1:0] eg;
        logic [N-1:0] ev;
        int gi;
        int j;
        @(negedge clock);
        hold = h;
        req_valid = v;
        req_a = a;
        req_b = b;
        #1;
        gi = -1;
        if (!h)
            for (int k = N; k >= 1; k--) begin
                j = (m_last + k) % N;
                if (v[j]) gi = j;
            end
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        chk("grant", 32'(req_ready), 32'(eg));
        chk("inflight", 32'(inflight), q.size());
        ev = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev[q[0].id] = 1'b1;
            chk("res_id", 32'(res_id), q[0].id);
            chk("res_data", 32'(res_data), 32'(q[0].p));
            void'(q.pop_front());
        end
        chk("res_valid", 32'(res_valid), 32'(ev));
        if (gi >= 0) begin
            q.push_back('{cyc + 2, gi, prod_top(a[gi*AW +: AW], b[gi*BW +: BW])});
            m_last = gi;
            n_ops++;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clock);
        aclr = 1'b1;
        hold = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_dataa", 32'(mult_dataa), 0);
        chk("rst_datab", 32'(mult_datab), 0);
        q.delete();
        m_last = N - 1;
        @(negedge clock);
        aclr = 1'b0;
        cyc += 2;
    endtask

    initial begin
        do_reset();
        // single op from requester 0
        ra = '0; rb = '0;
        ra[0*AW +: AW] = 12'd2047; rb[0*BW +: BW] = 14'd8191;
        cyc_step(1'b0, 4'b0001, ra, rb);
        for (int i = 0; i < 3; i++) cyc_step(1'b0, 4'b0000, ra, rb);
        // requester 2, most negative a
        ra[2*AW +: AW] = 12'h800; rb[2*BW +: BW] = 14'd8191;
        cyc_step(1'b0, 4'b0100, ra, rb);
        cyc_step(1'b0, 4'b0000, ra, rb);
        cyc_step(1'b0, 4'b0000, ra, rb);
        chk("neg_data", 32'(res_data), 32'h0000C002);
        chk("neg_valid", 32'(res_valid), 32'b0100);
        // single requester held valid is granted every cycle
        for (int i = 0; i < 4; i++) cyc_step(1'b0, 4'b0100, ra, rb);
        for (int i = 0; i < 2; i++) cyc_step(1'b0, 4'b0000, ra, rb);
        // all four valid: strict rotation, results i+1
        for (int i = 0; i < N; i++) begin
            ra[i*AW +: AW] = AW'(i + 1);
            rb[i*BW +: BW] = 14'd1024;
        end
        for (int i = 0; i < 8; i++) cyc_step(1'b0, 4'b1111, ra, rb);
        for (int i = 0; i < 2; i++) cyc_step(1'b0, 4'b0000, ra, rb);
        // hold with requests pending, then rotation resumes after requester 1
        cyc_step(1'b0, 4'b0010, ra, rb);
        for (int i = 0; i < 3; i++) cyc_step(1'b1, 4'b1111, ra, rb);
        for (int i = 0; i < 3; i++) cyc_step(1'b0, 4'b1111, ra, rb);
        for (int i = 0; i < 2; i++) cyc_step(1'b0, 4'b0000, ra, rb);
        // reset one cycle after a handshake discards it
        cyc_step(1'b0, 4'b1000, ra, rb);
        do_reset();
        cyc_step(1'b0, 4'b1100, ra, rb);
        for (int i = 0; i < 3; i++) cyc_step(1'b0, 4'b0000, ra, rb);
        // randomized run
        n_ops = 0;
        for (int c = 0; c < 6000 && n_ops < 1000; c++) begin
            for (int i = 0; i < N; i++) begin
                ra[i*AW +: AW] = AW'($urandom);
                rb[i*BW +: BW] = BW'($urandom);
            end
            cyc_step($urandom_range(0, 9) == 0, N'($urandom), ra, rb);
        end
        for (int i = 0; i < 3; i++) cyc_step(1'b0, 4'b0000, ra, rb);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
